bch_encoder_multi_mode: RTL and testbench

BCH_ENCODER_MULTI_MODE -- requirements
Module: bch_encoder_multi_mode

---
 rtl/bch_enc_pkg.sv | 14 +
 rtl/bch_parallel_lfsr.sv | 26 ++
 rtl/bch_encoder_multi_mode.sv | 140 ++++++++++++++
 tb/tb_bch_encoder_multi_mode.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_enc_pkg.sv
// Shared constants and state encoding for the multi-mode BCH encoder.
// Generator polynomials list coefficients x^(PARITY_LEN-1)..x^0; the leading x^PARITY_LEN term is implicit.
package bch_enc_pkg;

  localparam logic [167:0] GEN_POLY0 = 168'hB4_F3A1_9C27_D5E0_6B18_4F92_C3D7_0A65_E81B_3C49_F2D7;
  localparam logic [111:0] GEN_POLY1 = 112'h9E37_79B9_7F4A_7C15_F39C_C060_5CED;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } encState_t;

endpackage

// File: rtl/bch_parallel_lfsr.sv
// Combinational systematic-encoder LFSR step: folds one DATA_W-bit message beat (MSB first)
// into the current parity remainder.
module bch_parallel_lfsr #(
  parameter int                    DATA_W     = 8,
  parameter int                    PARITY_LEN = 168,
  parameter logic [PARITY_LEN-1:0] GEN_POLY   = '1
) (
  input  logic [DATA_W-1:0]     iData,
  input  logic [PARITY_LEN-1:0] iParity,
  output logic [PARITY_LEN-1:0] oParity
);

  logic feedback;

  // NOTE: blocking assignments chain the per-bit steps within one cycle, and both outputs
  // get a default first so no latch is inferred.
  always_comb begin
    oParity  = iParity;
    feedback = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      feedback = iData[i] ^ oParity[PARITY_LEN-1];
      oParity  = {oParity[PARITY_LEN-2:0], 1'b0} ^ (feedback ? GEN_POLY : '0);
    end
  end

endmodule

// File: rtl/bch_encoder_multi_mode.sv
// Two-strength systematic BCH encoder: passes MSG_BEATS data beats, then appends parity MSB-first.
// Optional macro BCH_ENC_BYPASS_EN adds iBypass, which sends the message without parity.
module bch_encoder_multi_mode
  import bch_enc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MSG_BEATS   = 256,
  parameter int PARITY_LEN0 = 168,
  parameter int PARITY_LEN1 = 112
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iMode,
`ifdef BCH_ENC_BYPASS_EN
  input  logic              iBypass,
`endif
  output logic              oEncoderAvailable,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDataValid,
  output logic              oDataReady,
  output logic [DATA_W-1:0] oEncodedData,
  output logic              oEncodedDataValid,
  output logic              oEncodedDataLast,
  input  logic              iReceiverReady
);

  localparam int IN_CNT_W   = $clog2(MSG_BEATS + 1);
  localparam int PAR_BEATS0 = PARITY_LEN0 / DATA_W;
  localparam int PAR_BEATS1 = PARITY_LEN1 / DATA_W;
  localparam int PAR_CNT_W  = $clog2(PAR_BEATS0 + 1);

  encState_t               state;
  logic                    modeLatched;
  logic                    bypassLatched;
  logic [PARITY_LEN0-1:0]  parityReg;
  logic [IN_CNT_W-1:0]     inCount;
  logic [PAR_CNT_W-1:0]    parCount;
  logic [PAR_CNT_W-1:0]    parBeats;
  logic [PARITY_LEN0-1:0]  nextParity0;
  logic [PARITY_LEN1-1:0]  nextParity1;
  logic [PARITY_LEN0-1:0]  nextParityMode1;
  logic                    accept;
  logic                    take;
  logic                    finalBeat;

  assign oEncoderAvailable = (state == IDLE);
  assign oDataReady        = (state == DATA) && (!oEncodedDataValid || iReceiverReady);
  assign accept            = iDataValid && oDataReady;
  assign take              = oEncodedDataValid && iReceiverReady;
  assign finalBeat         = (inCount == IN_CNT_W'(MSG_BEATS - 1));
  assign parBeats          = modeLatched ? PAR_CNT_W'(PAR_BEATS1) : PAR_CNT_W'(PAR_BEATS0);

  bch_parallel_lfsr #(
    .DATA_W    (DATA_W),
    .PARITY_LEN(PARITY_LEN0),
    .GEN_POLY  (GEN_POLY0)
  ) u_lfsr_mode0 (
    .iData  (iData),
    .iParity(parityReg),
    .oParity(nextParity0)
  );

  // Mode-1 remainder lives in the top PARITY_LEN1 bits so both modes drain from the same MSB.
  bch_parallel_lfsr #(
    .DATA_W    (DATA_W),
    .PARITY_LEN(PARITY_LEN1),
    .GEN_POLY  (GEN_POLY1)
  ) u_lfsr_mode1 (
    .iData  (iData),
    .iParity(parityReg[PARITY_LEN0-1 -: PARITY_LEN1]),
    .oParity(nextParity1)
  );

  assign nextParityMode1 = PARITY_LEN0'(nextParity1) << (PARITY_LEN0 - PARITY_LEN1);

`ifdef BCH_ENC_BYPASS_EN
  always_ff @(posedge iClock) begin
    if (!iReset)                        bypassLatched <= 1'b0;
    else if (state == IDLE && iEnable)  bypassLatched <= iBypass;
  end
`else
  assign bypassLatched = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state             <= IDLE;
      modeLatched       <= 1'b0;
      parityReg         <= '0;
      inCount           <= '0;
      parCount          <= '0;
      oEncodedData      <= '0;
      oEncodedDataValid <= 1'b0;
      oEncodedDataLast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iEnable) begin
            state       <= DATA;
            modeLatched <= iMode;
            parityReg   <= '0;
            inCount     <= '0;
            parCount    <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            oEncodedData      <= iData;
            oEncodedDataValid <= 1'b1;
            oEncodedDataLast  <= bypassLatched && finalBeat;
            parityReg         <= modeLatched ? nextParityMode1 : nextParity0;
            inCount           <= inCount + 1'b1;
            if (finalBeat) state <= PARITY;
          end else if (take) begin
            oEncodedDataValid <= 1'b0;
          end
        end
        PARITY: begin
          // The last data beat is still in the output register on entry; each take loads the next beat.
          if (take) begin
            if (oEncodedDataLast) begin
              state             <= IDLE;
              oEncodedDataValid <= 1'b0;
              oEncodedDataLast  <= 1'b0;
            end else begin
              oEncodedData     <= parityReg[PARITY_LEN0-1 -: DATA_W];
              parityReg        <= parityReg << DATA_W;
              parCount         <= parCount + 1'b1;
              oEncodedDataLast <= (parCount + 1'b1 == parBeats);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encoder_multi_mode.sv
// Scoreboard bench for bch_encoder_multi_mode; expected parity comes from polynomial long division.
module tb_bch_encoder_multi_mode;
  import bch_enc_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       iClock = 1'b0;
  logic       iReset = 1'b0;
  logic       iEnable = 1'b0;
  logic       iMode = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iDataValid = 1'b0;
  logic       iReceiverReady = 1'b1;
`ifdef BCH_ENC_BYPASS_EN
  logic       iBypass = 1'b0;
`endif
  logic       oEncoderAvailable;
  logic       oDataReady;
  logic [7:0] oEncodedData;
  logic       oEncodedDataValid;
  logic       oEncodedDataLast;

  int    checks = 0;
  int    errors = 0;
  beat_t expQ[$];
  beat_t obsQ[$];
  int    outCount = 0;
  int    lastIdx = 0;
  bit    lastSeen = 1'b0;
  bit    stallReady = 1'b0;

  always #5 iClock = ~iClock;

  bch_encoder_multi_mode dut (
    .iClock           (iClock),
    .iReset           (iReset),
    .iEnable          (iEnable),
    .iMode            (iMode),
`ifdef BCH_ENC_BYPASS_EN
    .iBypass          (iBypass),
`endif
    .oEncoderAvailable(oEncoderAvailable),
    .iData            (iData),
    .iDataValid       (iDataValid),
    .oDataReady       (oDataReady),
    .oEncodedData     (oEncodedData),
    .oEncodedDataValid(oEncodedDataValid),
    .oEncodedDataLast (oEncodedDataLast),
    .iReceiverReady   (iReceiverReady)
  );

  initial forever begin
    @(posedge iClock);
    #1;
    iReceiverReady = stallReady ? ~iReceiverReady : 1'b1;
  end

  // Scoreboard: every taken output beat is popped and compared.
  always @(negedge iClock) begin
    beat_t got;
    beat_t exp;
    if (iReset && oEncodedDataValid && iReceiverReady) begin
      got.data = oEncodedData;
      got.last = oEncodedDataLast;
      outCount++;
      obsQ.push_back(got);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: beat %0d got %h last=%b, required no beat", outCount, got.data, got.last);
      end else begin
        exp = expQ.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat_data: beat %0d got %h last=%b, required %h last=%b",
                   outCount, got.data, got.last, exp.data, exp.last);
        end
      end
      if (got.last) begin
        lastIdx  = outCount;
        lastSeen = 1'b1;
      end
    end
  end

  // Remainder of M(x)*x^len modulo g(x) by plain long division, aligned to the top of 168 bits.
  function automatic logic [167:0] ref_parity(input bit mode, input logic [7:0] msg[$]);
    int           len;
    logic [168:0] g;
    logic [168:0] r;
    len = mode ? 112 : 168;
    g   = mode ? {56'b0, 1'b1, GEN_POLY1} : {1'b1, GEN_POLY0};
    r   = '0;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        r = (r << 1) | 169'(msg[i][b]);
        if (r[len]) r = r ^ g;
      end
    end
    for (int z = 0; z < len; z++) begin
      r = r << 1;
      if (r[len]) r = r ^ g;
    end
    return r[167:0] << (168 - len);
  endfunction

  task automatic start_codeword(input bit mode, input logic [7:0] msg[$], input bit bypass);
    logic [167:0] p;
    beat_t        bt;
    int           nb;
    expQ.delete();
    obsQ.delete();
    outCount = 0;
    lastIdx  = 0;
    lastSeen = 1'b0;
    p  = ref_parity(mode, msg);
    nb = mode ? 14 : 21;
    foreach (msg[i]) begin
      bt.data = msg[i];
      bt.last = bypass && (i == msg.size() - 1);
      expQ.push_back(bt);
    end
    if (!bypass) begin
      for (int k = 0; k < nb; k++) begin
        bt.data = p[167 - 8 * k -: 8];
        bt.last = (k == nb - 1);
        expQ.push_back(bt);
      end
    end
  endtask

  task automatic send_codeword(input bit mode, input logic [7:0] msg[$], input bit gaps,
                               input bit toggleMode, input int abortAt, input bit bypass);
    int waitCount;
    @(posedge iClock);
    #1;
    iEnable = 1'b1;
    iMode   = mode;
`ifdef BCH_ENC_BYPASS_EN
    iBypass = bypass;
`else
    if (bypass) $display("bypass requested in a build without it");
`endif
    @(posedge iClock);
    #1;
    iEnable = 1'b0;
    iMode   = ~mode;
    for (int i = 0; i < msg.size() && i < abortAt; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          iDataValid = 1'b0;
          @(posedge iClock);
          #1;
        end
      end
      iData      = msg[i];
      iDataValid = 1'b1;
      if (toggleMode) begin
        iMode   = ~iMode;
        iEnable = 1'($urandom_range(0, 1));
      end
      waitCount = 0;
      do begin
        @(negedge iClock);
        waitCount++;
      end while (!oDataReady && waitCount < 1000);
      if (!oDataReady) begin
        checks++;
        errors++;
        $display("FAIL data_ready_timeout: beat %0d got ready=0, required ready=1", i);
        break;
      end
      @(posedge iClock);
      #1;
    end
    iDataValid = 1'b0;
    iEnable    = 1'b0;
  endtask

  task automatic wait_done(input int expLast, input string name);
    int n = 0;
    while (!lastSeen && n < 5000) begin
      @(posedge iClock);
      #2;
      n++;
    end
    checks++;
    if (!lastSeen) begin
      errors++;
      $display("FAIL %s_timeout: got no last beat, required last on beat %0d", name, expLast);
    end else begin
      checks++;
      if (lastIdx !== expLast) begin
        errors++;
        $display("FAIL %s_last_index: got %0d, required %0d", name, lastIdx, expLast);
      end
      checks++;
      if (oEncoderAvailable !== 1'b1) begin
        errors++;
        $display("FAIL %s_available: got %b, required 1", name, oEncoderAvailable);
      end
    end
    repeat (3) @(posedge iClock);
    #2;
    checks++;
    if (expQ.size() != 0 || outCount != expLast) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d beats with %0d pending, required %0d beats with 0 pending",
               name, outCount, expQ.size(), expLast);
    end
  endtask

  function automatic void rand_msg(output logic [7:0] msg[$]);
    msg.delete();
    for (int i = 0; i < 256; i++) msg.push_back(8'($urandom_range(0, 255)));
  endfunction

  task automatic test_reset();
    iReset = 1'b0;
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    checks++;
    if ({oEncodedDataValid, oEncodedDataLast, oDataReady, oEncoderAvailable, oEncodedData} !== {4'b0001, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b ready=%b avail=%b data=%h, required 0 0 0 1 00",
               oEncodedDataValid, oEncodedDataLast, oDataReady, oEncoderAvailable, oEncodedData);
    end
    @(posedge iClock);
    #1;
    iReset = 1'b1;
  endtask

  task automatic test_zero_mode0();
    logic [7:0] msg[$];
    for (int i = 0; i < 256; i++) msg.push_back(8'h00);
    stallReady = 1'b0;
    start_codeword(1'b0, msg, 1'b0);
    send_codeword(1'b0, msg, 1'b0, 1'b0, 256, 1'b0);
    wait_done(277, "zero_mode0");
  endtask

  task automatic test_random_mode1();
    logic [7:0] msg[$];
    rand_msg(msg);
    stallReady = 1'b0;
    start_codeword(1'b1, msg, 1'b0);
    send_codeword(1'b1, msg, 1'b0, 1'b0, 256, 1'b0);
    wait_done(270, "random_mode1");
  endtask

  task automatic test_stall();
    logic [7:0] msg[$];
    beat_t      ref_run[$];
    rand_msg(msg);
    stallReady = 1'b0;
    start_codeword(1'b0, msg, 1'b0);
    send_codeword(1'b0, msg, 1'b0, 1'b0, 256, 1'b0);
    wait_done(277, "unstalled");
    ref_run = obsQ;
    stallReady = 1'b1;
    start_codeword(1'b0, msg, 1'b0);
    send_codeword(1'b0, msg, 1'b1, 1'b0, 256, 1'b0);
    wait_done(277, "stalled");
    stallReady = 1'b0;
    checks++;
    if (obsQ.size() != ref_run.size()) begin
      errors++;
      $display("FAIL stall_length: got %0d beats, required %0d", obsQ.size(), ref_run.size());
    end else begin
      foreach (ref_run[i]) begin
        checks++;
        if (obsQ[i] !== ref_run[i]) begin
          errors++;
          $display("FAIL stall_sequence: beat %0d got %h, required %h", i + 1, obsQ[i], ref_run[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] msg[$];
    int         seen;
    rand_msg(msg);
    stallReady = 1'b0;
    start_codeword(1'b0, msg, 1'b0);
    send_codeword(1'b0, msg, 1'b0, 1'b0, 100, 1'b0);
    iReset = 1'b0;
    @(posedge iClock);
    #1;
    checks++;
    if ({oEncodedDataValid, oEncodedDataLast, oDataReady, oEncoderAvailable} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_outputs: got valid=%b last=%b ready=%b avail=%b, required 0 0 0 1",
               oEncodedDataValid, oEncodedDataLast, oDataReady, oEncoderAvailable);
    end
    iReset = 1'b1;
    expQ.delete();
    seen = obsQ.size();
    repeat (5) @(posedge iClock);
    #2;
    checks++;
    if (obsQ.size() != seen) begin
      errors++;
      $display("FAIL reset_mid_abort: got %0d beats after reset, required 0", obsQ.size() - seen);
    end
    rand_msg(msg);
    start_codeword(1'b0, msg, 1'b0);
    send_codeword(1'b0, msg, 1'b0, 1'b0, 256, 1'b0);
    wait_done(277, "after_reset");
  endtask

  task automatic test_mode_toggle();
    logic [7:0] msg[$];
    stallReady = 1'b0;
    rand_msg(msg);
    start_codeword(1'b0, msg, 1'b0);
    send_codeword(1'b0, msg, 1'b0, 1'b1, 256, 1'b0);
    wait_done(277, "toggle_mode0");
    rand_msg(msg);
    start_codeword(1'b1, msg, 1'b0);
    send_codeword(1'b1, msg, 1'b1, 1'b1, 256, 1'b0);
    wait_done(270, "toggle_mode1");
  endtask

`ifdef BCH_ENC_BYPASS_EN
  task automatic test_bypass();
    logic [7:0] msg[$];
    stallReady = 1'b0;
    rand_msg(msg);
    start_codeword(1'b0, msg, 1'b1);
    send_codeword(1'b0, msg, 1'b0, 1'b0, 256, 1'b1);
    wait_done(256, "bypass");
    iBypass = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_mode0();
    test_random_mode1();
    test_stall();
    test_reset_mid();
    test_mode_toggle();
`ifdef BCH_ENC_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
